// File: rtl/holo_pkg.sv
// rtl/holo_pkg.sv - shared RV32I load/store constants, size decode and LSU state enum
package holo_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } lsu_state_t;

    function automatic logic is_mem_opcode(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    function automatic logic [2:0] f3_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    function automatic logic misaligned(input logic [1:0] addr_lo, input logic [2:0] size);
        return ((size == 3'd2) && addr_lo[0]) || ((size == 3'd4) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/holo_lsu_extend.sv
// rtl/holo_lsu_extend.sv - sign/zero extension of assembled load data by funct3
module holo_lsu_extend
    import holo_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [2:0]  f3,
    output logic [31:0] data
);

    always_comb begin
        data = raw;
        case (f3)
            F3_LB:   data = {{24{raw[7]}}, raw[7:0]};
            F3_LH:   data = {{16{raw[15]}}, raw[15:0]};
            F3_LW:   data = raw;
            F3_LBU:  data = {24'b0, raw[7:0]};
            F3_LHU:  data = {16'b0, raw[15:0]};
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/holo_lsu.sv
// rtl/holo_lsu.sv - load/store sequencer splitting RV32I accesses into BUS_W-wide memory beats
module holo_lsu
    import holo_pkg::*;
#(
    parameter int BUS_W    = 8,
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_f3,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 resp_valid,
    output logic [31:0]          resp_rdata,
    output logic                 resp_err,
    output logic                 mem_ce,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [BUS_W/8-1:0]   mem_be,
    output logic [BUS_W-1:0]     mem_wdata,
    input  logic [BUS_W-1:0]     mem_rdata,
    input  logic                 mem_ack
);

    localparam int BUS_BYTES = BUS_W / 8;
    localparam int LANE_W    = $clog2(BUS_BYTES);

    lsu_state_t state, state_nx;

    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] asm_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [2:0]  beat_q;
    logic [2:0]  nbeats_q;
    logic [15:0] wait_cnt;

    logic [2:0]  req_size;
    logic [2:0]  req_nbeats;
    logic        req_bad;
    logic [2:0]  size_q;
    logic [1:0]  lane_off;
    logic [4:0]  lane_shamt;
    logic [3:0]  be_word;
    logic [31:0] byte_mask;
    logic [31:0] beat_addr;
    int          beat_sh;
    logic [31:0] asm_nx;
    logic [31:0] ext_data;
    logic        last_beat;
    logic        hit_limit;
    logic        in_access;

    always_comb begin
        req_size   = f3_size(req_f3);
        req_nbeats = (int'(req_size) > BUS_BYTES) ? (req_size >> LANE_W) : 3'd1;
        req_bad    = !f3_legal(req_we, req_f3) || misaligned(req_addr[1:0], req_size);
    end

    // Sub-bus accesses are a single beat placed at the request's lane offset;
    // wider accesses are bus-aligned, so the offset is zero for every beat.
    always_comb begin
        size_q     = f3_size(f3_q);
        lane_off   = addr_q[1:0] & 2'(BUS_BYTES - 1);
        lane_shamt = {lane_off, 3'b000};
        case (size_q)
            3'd1:    be_word = 4'b0001;
            3'd2:    be_word = 4'b0011;
            default: be_word = 4'b1111;
        endcase
        byte_mask  = {{8{be_word[3]}}, {8{be_word[2]}}, {8{be_word[1]}}, {8{be_word[0]}}};
        beat_sh    = int'(beat_q) * BUS_W;
        beat_addr  = (addr_q & ~32'(BUS_BYTES - 1)) + (32'(beat_q) << LANE_W);
        asm_nx     = asm_q | ((32'(mem_rdata) >> lane_shamt) << beat_sh);
        last_beat  = (beat_q == nbeats_q - 3'd1);
        hit_limit  = (MAX_WAIT > 0) && (wait_cnt == 16'(MAX_WAIT - 1));
    end

    holo_lsu_extend u_extend (
        .raw  (asm_nx),
        .f3   (f3_q),
        .data (ext_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (req_valid)
                    state_nx = req_bad ? ST_RESP : ST_ACCESS;
            end
            ST_ACCESS: begin
                if (mem_ack) begin
                    if (last_beat)
                        state_nx = ST_RESP;
                end else if (hit_limit) begin
                    state_nx = ST_RESP;
                end
            end
            ST_RESP:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            f3_q     <= 3'b0;
            addr_q   <= 32'b0;
            wdata_q  <= 32'b0;
            asm_q    <= 32'b0;
            rdata_q  <= 32'b0;
            err_q    <= 1'b0;
            beat_q   <= 3'b0;
            nbeats_q <= 3'b0;
            wait_cnt <= 16'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        f3_q     <= req_f3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        asm_q    <= 32'b0;
                        rdata_q  <= 32'b0;
                        err_q    <= req_bad;
                        beat_q   <= 3'b0;
                        nbeats_q <= req_nbeats;
                        wait_cnt <= 16'b0;
                    end
                end
                ST_ACCESS: begin
                    if (mem_ack) begin
                        asm_q    <= asm_nx;
                        beat_q   <= beat_q + 3'd1;
                        wait_cnt <= 16'b0;
                        if (last_beat)
                            rdata_q <= we_q ? 32'b0 : ext_data;
                    end else if (hit_limit) begin
                        err_q   <= 1'b1;
                        rdata_q <= 32'b0;
                    end else if (MAX_WAIT > 0) begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // All bus outputs are forced to zero outside ACCESS so reset and abort drop them at once.
    assign in_access  = (state == ST_ACCESS);
    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);
    assign resp_err   = (state == ST_RESP) && err_q;
    assign resp_rdata = (state == ST_RESP) ? rdata_q : 32'b0;
    assign mem_ce     = in_access;
    assign mem_we     = in_access && we_q;
    assign mem_addr   = in_access ? ADDR_W'(beat_addr) : '0;
    assign mem_be     = in_access ? BUS_BYTES'(be_word << lane_off) : '0;
    assign mem_wdata  = in_access ? BUS_W'(((wdata_q & byte_mask) >> beat_sh) << lane_shamt) : '0;

endmodule

// File: tb/tb_holo_lsu.sv
// tb/tb_holo_lsu.sv - directed self-checking bench for holo_lsu on 8/16/32-bit buses
module tb_holo_lsu;
    import holo_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] memb [0:255];

    logic        v8, rdy8, we8, rv8, err8, ce8, mwe8, ack8;
    logic [2:0]  f38;
    logic [31:0] a8, wd8, rd8, ma8;
    logic [0:0]  be8;
    logic [7:0]  mwd8, mrd8;

    logic        v16, rdy16, we16, rv16, err16, ce16, mwe16, ack16;
    logic [2:0]  f316;
    logic [31:0] a16, wd16, rd16, ma16;
    logic [1:0]  be16;
    logic [15:0] mwd16, mrd16;

    logic        v32, rdy32, we32, rv32, err32, ce32, mwe32, ack32;
    logic [2:0]  f332;
    logic [31:0] a32, wd32, rd32, ma32;
    logic [3:0]  be32;
    logic [31:0] mwd32, mrd32;

    assign mrd8  = memb[ma8[7:0]];
    assign mrd16 = {memb[ma16[7:0] + 8'd1], memb[ma16[7:0]]};
    assign mrd32 = {memb[ma32[7:0] + 8'd3], memb[ma32[7:0] + 8'd2],
                    memb[ma32[7:0] + 8'd1], memb[ma32[7:0]]};

    holo_lsu #(.BUS_W(8), .ADDR_W(32), .MAX_WAIT(3)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .req_valid(v8), .req_ready(rdy8), .req_we(we8),
        .req_f3(f38), .req_addr(a8), .req_wdata(wd8), .resp_valid(rv8),
        .resp_rdata(rd8), .resp_err(err8), .mem_ce(ce8), .mem_we(mwe8),
        .mem_addr(ma8), .mem_be(be8), .mem_wdata(mwd8), .mem_rdata(mrd8), .mem_ack(ack8)
    );

    holo_lsu #(.BUS_W(16), .ADDR_W(32), .MAX_WAIT(15)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .req_valid(v16), .req_ready(rdy16), .req_we(we16),
        .req_f3(f316), .req_addr(a16), .req_wdata(wd16), .resp_valid(rv16),
        .resp_rdata(rd16), .resp_err(err16), .mem_ce(ce16), .mem_we(mwe16),
        .mem_addr(ma16), .mem_be(be16), .mem_wdata(mwd16), .mem_rdata(mrd16), .mem_ack(ack16)
    );

    holo_lsu #(.BUS_W(32), .ADDR_W(32), .MAX_WAIT(15)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .req_valid(v32), .req_ready(rdy32), .req_we(we32),
        .req_f3(f332), .req_addr(a32), .req_wdata(wd32), .resp_valid(rv32),
        .resp_rdata(rd32), .resp_err(err32), .mem_ce(ce32), .mem_we(mwe32),
        .mem_addr(ma32), .mem_be(be32), .mem_wdata(mwd32), .mem_rdata(mrd32), .mem_ack(ack32)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start8(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        chk("rdy8_before_accept", {31'b0, rdy8}, 32'd1);
        v8 = 1'b1; we8 = we; f38 = f3; a8 = addr; wd8 = 32'h0;
        tick;
        v8 = 1'b0;
    endtask

    task automatic load32(input logic [2:0] f3, input logic [31:0] addr,
                          input logic [3:0] be_exp, input logic [31:0] exp);
        v32 = 1'b1; we32 = 1'b0; f332 = f3; a32 = addr; wd32 = 32'h0;
        tick;
        v32 = 1'b0;
        chk($sformatf("ld32_ce_%h", addr), {31'b0, ce32}, 32'd1);
        chk($sformatf("ld32_addr_%h", addr), ma32, 32'h20);
        chk($sformatf("ld32_be_%h", addr), {28'b0, be32}, {28'b0, be_exp});
        tick;
        chk($sformatf("ld32_rv_%h", addr), {31'b0, rv32}, 32'd1);
        chk($sformatf("ld32_rdata_%h", addr), rd32, exp);
        chk($sformatf("ld32_err_%h", addr), {31'b0, err32}, 32'd0);
        tick;
    endtask

    initial begin
        v8 = 0; we8 = 0; f38 = 0; a8 = 0; wd8 = 0; ack8 = 1;
        v16 = 0; we16 = 0; f316 = 0; a16 = 0; wd16 = 0; ack16 = 1;
        v32 = 0; we32 = 0; f332 = 0; a32 = 0; wd32 = 0; ack32 = 1;
        for (int i = 0; i < 256; i++) memb[i] = 8'h00;
        memb[8'h10] = 8'h78; memb[8'h11] = 8'h56; memb[8'h12] = 8'h34; memb[8'h13] = 8'h12;
        memb[8'h20] = 8'h01; memb[8'h21] = 8'h7F; memb[8'h22] = 8'hFF; memb[8'h23] = 8'h80;

        tick;
        tick;
        chk("rst_ready", {31'b0, rdy8}, 32'd1);
        chk("rst_resp_valid", {31'b0, rv8}, 32'd0);
        chk("rst_resp_err", {31'b0, err8}, 32'd0);
        chk("rst_resp_rdata", rd8, 32'd0);
        chk("rst_mem_ce", {31'b0, ce8}, 32'd0);
        chk("rst_mem_addr", ma8, 32'd0);
        chk("rst_mem_be", {31'b0, be8}, 32'd0);
        chk("rst_mem_wdata", {24'b0, mwd8}, 32'd0);
        rst_n = 1'b1;
        tick;

        // 8-bit bus LW: four byte beats, response at cycle 5
        start8(1'b0, F3_LW, 32'h10);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("lw8_ce_b%0d", k), {31'b0, ce8}, 32'd1);
            chk($sformatf("lw8_addr_b%0d", k), ma8, 32'h10 + k);
            chk($sformatf("lw8_be_b%0d", k), {31'b0, be8}, 32'd1);
            chk($sformatf("lw8_we_b%0d", k), {31'b0, mwe8}, 32'd0);
            chk($sformatf("lw8_rv_b%0d", k), {31'b0, rv8}, 32'd0);
            tick;
        end
        chk("lw8_rv", {31'b0, rv8}, 32'd1);
        chk("lw8_rdata", rd8, 32'h12345678);
        chk("lw8_err", {31'b0, err8}, 32'd0);
        chk("lw8_ce_in_resp", {31'b0, ce8}, 32'd0);
        chk("lw8_ready_in_resp", {31'b0, rdy8}, 32'd0);
        tick;
        chk("lw8_ready_after", {31'b0, rdy8}, 32'd1);
        chk("lw8_rv_after", {31'b0, rv8}, 32'd0);

        // 32-bit bus sub-word loads with sign/zero extension
        load32(F3_LB,  32'h23, 4'b1000, 32'hFFFFFF80);
        load32(F3_LBU, 32'h23, 4'b1000, 32'h00000080);
        load32(F3_LH,  32'h22, 4'b1100, 32'hFFFF80FF);
        load32(F3_LHU, 32'h20, 4'b0011, 32'h00007F01);

        // 32-bit bus SB into lane 1
        v32 = 1'b1; we32 = 1'b1; f332 = F3_SB; a32 = 32'h21; wd32 = 32'h123456AB;
        tick;
        v32 = 1'b0;
        chk("sb32_we", {31'b0, mwe32}, 32'd1);
        chk("sb32_be", {28'b0, be32}, 32'h2);
        chk("sb32_wdata", mwd32, 32'h0000AB00);
        tick;
        chk("sb32_rv", {31'b0, rv32}, 32'd1);
        chk("sb32_rdata", rd32, 32'd0);
        tick;

        // 16-bit bus SW: two halfword beats
        v16 = 1'b1; we16 = 1'b1; f316 = F3_SW; a16 = 32'h40; wd16 = 32'hDEADBEEF;
        tick;
        v16 = 1'b0;
        chk("sw16_ce_b0", {31'b0, ce16}, 32'd1);
        chk("sw16_we_b0", {31'b0, mwe16}, 32'd1);
        chk("sw16_addr_b0", ma16, 32'h40);
        chk("sw16_be_b0", {30'b0, be16}, 32'h3);
        chk("sw16_wdata_b0", {16'b0, mwd16}, 32'hBEEF);
        tick;
        chk("sw16_we_b1", {31'b0, mwe16}, 32'd1);
        chk("sw16_addr_b1", ma16, 32'h42);
        chk("sw16_be_b1", {30'b0, be16}, 32'h3);
        chk("sw16_wdata_b1", {16'b0, mwd16}, 32'hDEAD);
        tick;
        chk("sw16_rv", {31'b0, rv16}, 32'd1);
        chk("sw16_rdata", rd16, 32'd0);
        chk("sw16_err", {31'b0, err16}, 32'd0);
        tick;

        // Errors at accept: response at cycle 1, no bus activity
        start8(1'b0, F3_LW, 32'h41);
        chk("mis_lw8_ce", {31'b0, ce8}, 32'd0);
        chk("mis_lw8_rv", {31'b0, rv8}, 32'd1);
        chk("mis_lw8_err", {31'b0, err8}, 32'd1);
        chk("mis_lw8_rdata", rd8, 32'd0);
        tick;
        chk("mis_lw8_ready", {31'b0, rdy8}, 32'd1);

        v16 = 1'b1; we16 = 1'b0; f316 = F3_LH; a16 = 32'h43;
        tick;
        v16 = 1'b0;
        chk("mis_lh16_ce", {31'b0, ce16}, 32'd0);
        chk("mis_lh16_err", {31'b0, err16}, 32'd1);
        tick;

        v32 = 1'b1; we32 = 1'b0; f332 = 3'b011; a32 = 32'h20;
        tick;
        v32 = 1'b0;
        chk("ill_ld32_ce", {31'b0, ce32}, 32'd0);
        chk("ill_ld32_rv", {31'b0, rv32}, 32'd1);
        chk("ill_ld32_err", {31'b0, err32}, 32'd1);
        tick;

        v32 = 1'b1; we32 = 1'b1; f332 = 3'b100; a32 = 32'h20;
        tick;
        v32 = 1'b0;
        chk("ill_st32_ce", {31'b0, ce32}, 32'd0);
        chk("ill_st32_err", {31'b0, err32}, 32'd1);
        tick;

        // Timeout with MAX_WAIT=3 and ack held low
        ack8 = 1'b0;
        start8(1'b0, F3_LW, 32'h10);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("to_ce_c%0d", i + 1), {31'b0, ce8}, 32'd1);
            chk($sformatf("to_addr_c%0d", i + 1), ma8, 32'h10);
            tick;
        end
        chk("to_ce_off", {31'b0, ce8}, 32'd0);
        chk("to_rv", {31'b0, rv8}, 32'd1);
        chk("to_err", {31'b0, err8}, 32'd1);
        chk("to_rdata", rd8, 32'd0);
        tick;

        // Ack arriving in the limit cycle wins
        start8(1'b0, F3_LB, 32'h12);
        chk("late_ce_c1", {31'b0, ce8}, 32'd1);
        tick;
        chk("late_ce_c2", {31'b0, ce8}, 32'd1);
        tick;
        chk("late_ce_c3", {31'b0, ce8}, 32'd1);
        ack8 = 1'b1;
        tick;
        chk("late_rv", {31'b0, rv8}, 32'd1);
        chk("late_err", {31'b0, err8}, 32'd0);
        chk("late_rdata", rd8, 32'h00000034);
        tick;

        // Reset during beat 2 of an LW
        start8(1'b0, F3_LW, 32'h10);
        tick;
        chk("rst_mid_addr_b2", ma8, 32'h11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ce", {31'b0, ce8}, 32'd0);
        chk("rst_mid_addr", ma8, 32'd0);
        chk("rst_mid_be", {31'b0, be8}, 32'd0);
        chk("rst_mid_rv", {31'b0, rv8}, 32'd0);
        chk("rst_mid_ready", {31'b0, rdy8}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        start8(1'b0, F3_LB, 32'h13);
        chk("post_rst_addr", ma8, 32'h13);
        tick;
        chk("post_rst_rv", {31'b0, rv8}, 32'd1);
        chk("post_rst_rdata", rd8, 32'h00000012);
        chk("post_rst_err", {31'b0, err8}, 32'd0);
        tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/holo_lsu.md
Name: holo_lsu

Overview:
- Parametrised load/store sequencer between the RV32I core's execute stage and the data memory.
- Accepts one 32-bit load or store request (funct3-encoded size/sign).
- Serialises the request into BUS_W-wide beats with byte enables and tolerates memory wait states.
- Returns sign/zero-extended load data or an error for misaligned, illegal or timed-out accesses.
- Generalises the core's fixed 8-bit byte-per-cycle load/store sequencing to 8/16/32-bit buses with a handshake.

Parameters:
- BUS_W, 8: memory data bus width in bits; legal values 8, 16, 32; BUS_BYTES = BUS_W/8.
- ADDR_W, 32: memory byte-address width.
- MAX_WAIT, 15: maximum cycles a beat waits for mem_ack before aborting; 0 disables the timeout.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; transfer occurs when req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_f3  in  3  RV32I funct3: loads LB/LH/LW/LBU/LHU, stores SB/SH/SW
- req_addr  in  32  byte address (rs1 + imm, computed by core)
- req_wdata  in  32  store data (rs2), low bytes used for SB/SH
- resp_valid  out  1  one-cycle pulse, completion
- resp_rdata  out  32  extended load data, 0 for stores and errors
- resp_err  out  1  valid with resp_valid: misaligned, illegal f3 or timeout
- mem_ce  out  1  beat active
- mem_we  out  1  beat is a write
- mem_addr  out  ADDR_W  bus-word-aligned byte address of beat
- mem_be  out  BUS_BYTES  byte-lane enables
- mem_wdata  out  BUS_W  write lanes
- mem_rdata  in  BUS_W  read lanes, sampled when mem_ack high
- mem_ack  in  1  beat completes this cycle (may be combinational from mem_ce)

Behaviour:
- Reset, asynchronous: state IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; mem_ce=0; mem_we=0; mem_addr=0; mem_be=0; mem_wdata=0; timeout counter 0.
- Reset asserted mid-access abandons the access with no response. Memory must tolerate the dropped mem_ce.
- States: IDLE -> ACCESS -> RESP -> IDLE. IDLE -> RESP directly on error at accept.
- Accept, IDLE with req_valid: latch we, f3, addr, wdata.
  - SIZE = 1/2/4 bytes from f3[1:0].
  - Illegal f3: load 011/110/111, store >= 011. Illegal f3 or addr % SIZE != 0 -> RESP with err=1, no bus activity.
- Beat count: NBEATS = max(1, SIZE/BUS_BYTES).
  - Beat k drives mem_addr = (addr & ~(BUS_BYTES-1)) + k*BUS_BYTES.
  - mem_be = lanes covering bytes [addr%BUS_BYTES, +min(SIZE,BUS_BYTES)). Little-endian.
  - mem_wdata carries store bytes shifted into their lanes; unused lanes are 0.
- ACCESS:
  - mem_ce=1; outputs held stable until mem_ack.
  - On ack, load lanes are captured into an assembly register; the next beat is driven the following cycle, or RESP after the last beat.
  - Minimum latency, ack always high: accept at cycle 0, beats at cycles 1..NBEATS, resp_valid at cycle NBEATS+1, req_ready again at NBEATS+2.
- Timeout: the counter clears at each beat start and increments per cycle without ack. Reaching MAX_WAIT (MAX_WAIT>0) -> mem_ce=0, RESP with err=1, rdata=0. An ack in the same cycle the limit is reached wins.
- RESP: one cycle of resp_valid.
  - rdata: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW raw; stores 0.
  - mem_ce=0 in RESP and IDLE.
- req_valid outside IDLE is ignored (req_ready=0).
- No bus activity without an accepted request.

Decomposition:
- Package holo_pkg: opcode and funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW), size decode function, LSU state enum.
- Shared with the core's decode/execute logic.
- Sub-module holo_lsu_extend (combinational): takes assembled 32-bit raw data and f3, returns the extended result. It is reused by any future cache path.

Test Plan:
- BUS_W=8, memory bytes 0x10..0x13 = 78 56 34 12, ack tied high: LW addr 0x10 -> 4 beats at 0x10..0x13 with be=1; resp at cycle 5, rdata 0x12345678, err=0.
- BUS_W=32, word at 0x20 = 0x80FF7F01: LB 0x23 -> 1 beat, be=1000, rdata 0xFFFFFF80. LBU 0x23 -> 0x00000080. LH 0x22 -> 0xFFFF80FF. LHU 0x20 -> 0x00007F01.
- BUS_W=16, SW addr 0x40 data 0xDEADBEEF -> beats (0x40, be=11, wdata 0xBEEF) then (0x42, be=11, wdata 0xDEAD); mem_we=1; resp rdata 0, err 0.
- Any BUS_W, LW 0x41 or LH 0x43 or load f3=011 -> resp_valid at cycle 1 with err=1; mem_ce never asserted.
- BUS_W=8, MAX_WAIT=3, ack held low -> mem_ce high 3 cycles then low; resp err=1, rdata 0. Repeat with ack on cycle 3 -> completes normally.
- Assert rst_n low mid-beat 2 of an LW -> mem_ce and all outputs 0 immediately; after release, req_ready=1 and a new LB completes correctly.
